// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard unit.
package hazard_pkg;

    localparam int unsigned RegAddrW  = 4;
    localparam int unsigned StallCntW = 16;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_REG = 2'b00;
    localparam fwd_sel_t FWD_MA  = 2'b01;
    localparam fwd_sel_t FWD_WB  = 2'b10;

    localparam logic [RegAddrW-1:0] REG_ZERO = 4'd0;
    localparam logic [RegAddrW-1:0] REG_RA   = 4'd15;

    // One in-flight producer per pipeline stage.
    typedef struct packed {
        logic                valid;
        logic [RegAddrW-1:0] waddr;
        logic                is_load;
    } slot_t;

    // Youngest producer wins: EX result beats MA result.
    function automatic fwd_sel_t fwd_pick(input logic hit_ex, input logic hit_ma);
        if (hit_ex) return FWD_MA;
        if (hit_ma) return FWD_WB;
        return FWD_REG;
    endfunction

endpackage

// File: rtl/hazard_if.sv
// Decode-stage to hazard-unit signal bundle; the hazard unit is the slave side.
interface hazard_if;

    logic                                 id_valid;
    logic [hazard_pkg::RegAddrW-1:0]      id_rs_addr;
    logic [hazard_pkg::RegAddrW-1:0]      id_rt_addr;
    logic                                 id_rs_used;
    logic                                 id_rt_used;
    logic                                 id_wr;
    logic [hazard_pkg::RegAddrW-1:0]      id_waddr;
    logic                                 id_is_load;
    logic                                 flush;
    logic                                 stall;
    hazard_pkg::fwd_sel_t                 fwd_rs_sel;
    hazard_pkg::fwd_sel_t                 fwd_rt_sel;
    logic [hazard_pkg::StallCntW-1:0]     stall_cnt;

    modport master (
        output id_valid, id_rs_addr, id_rt_addr, id_rs_used, id_rt_used,
        output id_wr, id_waddr, id_is_load, flush,
        input  stall, fwd_rs_sel, fwd_rt_sel, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs_addr, id_rt_addr, id_rs_used, id_rt_used,
        input  id_wr, id_waddr, id_is_load, flush,
        output stall, fwd_rs_sel, fwd_rt_sel, stall_cnt
    );

endinterface

// File: rtl/hazard_match.sv
// Compares one decode-stage source operand against the EX and MA producer slots.
module hazard_match
    import hazard_pkg::*;
(
    input  logic                used,
    input  logic [RegAddrW-1:0] addr,
    input  slot_t               ex_slot,
    input  slot_t               ma_slot,
    output logic                hit_ex,
    output logic                hit_ma,
    output logic                load_hit
);

    logic src_live;
    logic unused_ma_load;

    // $r0 is hardwired, so it can never carry a dependency.
    assign src_live = used && (addr != REG_ZERO);

    assign hit_ex   = src_live && ex_slot.valid && (ex_slot.waddr == addr);
    assign hit_ma   = src_live && ma_slot.valid && (ma_slot.waddr == addr);
    assign load_hit = hit_ex && ex_slot.is_load;

    assign unused_ma_load = ma_slot.is_load;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline interlock and forwarding controller for the 16-bit core.
// Define HAZARD_FORWARD_EN to build with EX operand forwarding (only load-use stalls).
module hazard_unit
    import hazard_pkg::*;
(
    input logic     clk,
    input logic     rst,
    hazard_if.slave hz
);

    slot_t                 ex_q, ma_q, wb_q, ex_d;
    logic                  rs_used, rt_used;
    logic                  rs_hit_ex, rs_hit_ma, rs_load_hit;
    logic                  rt_hit_ex, rt_hit_ma, rt_load_hit;
    logic                  stall_c;
    logic [StallCntW-1:0]  stall_cnt_q, stall_cnt_d;
    logic                  unused_wb;

    assign rs_used = hz.id_valid && hz.id_rs_used;
    assign rt_used = hz.id_valid && hz.id_rt_used;

    hazard_match u_match_rs (
        .used     (rs_used),
        .addr     (hz.id_rs_addr),
        .ex_slot  (ex_q),
        .ma_slot  (ma_q),
        .hit_ex   (rs_hit_ex),
        .hit_ma   (rs_hit_ma),
        .load_hit (rs_load_hit)
    );

    hazard_match u_match_rt (
        .used     (rt_used),
        .addr     (hz.id_rt_addr),
        .ex_slot  (ex_q),
        .ma_slot  (ma_q),
        .hit_ex   (rt_hit_ex),
        .hit_ma   (rt_hit_ma),
        .load_hit (rt_load_hit)
    );

`ifdef HAZARD_FORWARD_EN
    assign stall_c = !hz.flush && (rs_load_hit || rt_load_hit);
`else
    logic unused_load;
    assign unused_load = rs_load_hit ^ rt_load_hit;
    assign stall_c = !hz.flush && (rs_hit_ex || rs_hit_ma || rt_hit_ex || rt_hit_ma);
`endif

    assign hz.stall     = stall_c;
    assign hz.stall_cnt = stall_cnt_q;

    // WB is tracked for completeness; the write-through regfile makes its hits harmless.
    assign unused_wb = ^wb_q;

    always_comb begin
        ex_d        = '0;
        stall_cnt_d = stall_cnt_q;
        if (hz.id_valid && hz.id_wr && (hz.id_waddr != REG_ZERO) && !stall_c && !hz.flush) begin
            ex_d.valid   = 1'b1;
            ex_d.waddr   = hz.id_waddr;
            ex_d.is_load = hz.id_is_load;
        end
        if (stall_c && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + StallCntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q        <= '0;
            ma_q        <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            ma_q        <= ex_q;
            wb_q        <= ma_q;
            stall_cnt_q <= stall_cnt_d;
        end
    end

`ifdef HAZARD_FORWARD_EN
    fwd_sel_t rs_sel_q, rs_sel_d;
    fwd_sel_t rt_sel_q, rt_sel_d;

    // A stalled or flushed decode sends a bubble into EX, which needs no forwarding.
    always_comb begin
        rs_sel_d = FWD_REG;
        rt_sel_d = FWD_REG;
        if (!stall_c && !hz.flush) begin
            rs_sel_d = fwd_pick(rs_hit_ex, rs_hit_ma);
            rt_sel_d = fwd_pick(rt_hit_ex, rt_hit_ma);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rs_sel_q <= FWD_REG;
            rt_sel_q <= FWD_REG;
        end else begin
            rs_sel_q <= rs_sel_d;
            rt_sel_q <= rt_sel_d;
        end
    end

    assign hz.fwd_rs_sel = rs_sel_q;
    assign hz.fwd_rt_sel = rt_sel_q;
`else
    assign hz.fwd_rs_sel = FWD_REG;
    assign hz.fwd_rt_sel = FWD_REG;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: producer-age reference model plus directed cases.
module tb_hazard_unit;
    import hazard_pkg::*;

`ifdef HAZARD_FORWARD_EN
    localparam bit FwdOn = 1'b1;
`else
    localparam bit FwdOn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    hazard_if hz ();

    hazard_unit dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit forced   = 1'b0;

    // Model: every issued producer with its age (0 = in EX, 1 = in MA, 2 = in WB).
    typedef struct {
        logic [3:0] addr;
        bit         is_load;
        int         age;
    } prod_t;

    prod_t       prods[$];
    logic [1:0]  exp_rs  = 2'b00;
    logic [1:0]  exp_rt  = 2'b00;
    logic [15:0] exp_cnt = 16'h0000;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, want, $time);
        end
    endtask

    function automatic int youngest(input logic used, input logic [3:0] a);
        int best = -1;
        if (!used || a == 4'd0) return -1;
        foreach (prods[i]) begin
            if (prods[i].addr == a && prods[i].age <= 1 &&
                (best < 0 || prods[i].age < prods[best].age)) best = i;
        end
        return best;
    endfunction

    function automatic bit src_stalls(input int k);
        if (k < 0) return 1'b0;
        if (!FwdOn) return 1'b1;
        return (prods[k].age == 0) && prods[k].is_load;
    endfunction

    function automatic logic [1:0] src_sel(input int k);
        if (!FwdOn || k < 0) return 2'b00;
        return (prods[k].age == 0) ? 2'b01 : 2'b10;
    endfunction

    // Compare process: check at each falling edge, then advance the model past the next rise.
    initial begin
        int    krs, krt;
        bit    st;
        prod_t p;
        forever begin
            @(negedge clk or negedge rst);
            if (!rst) begin
                prods.delete();
                exp_rs  = 2'b00;
                exp_rt  = 2'b00;
                exp_cnt = 16'h0000;
            end else if (!clk) begin
                krs = youngest(hz.id_valid && hz.id_rs_used, hz.id_rs_addr);
                krt = youngest(hz.id_valid && hz.id_rt_used, hz.id_rt_addr);
                st  = forced || (hz.id_valid && !hz.flush && (src_stalls(krs) || src_stalls(krt)));
                check("stall", {15'd0, hz.stall}, {15'd0, st});
                check("fwd_rs_sel", {14'd0, hz.fwd_rs_sel}, {14'd0, exp_rs});
                check("fwd_rt_sel", {14'd0, hz.fwd_rt_sel}, {14'd0, exp_rt});
                check("stall_cnt", hz.stall_cnt, exp_cnt);
                exp_rs = (st || hz.flush) ? 2'b00 : src_sel(krs);
                exp_rt = (st || hz.flush) ? 2'b00 : src_sel(krt);
                if (st && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
                for (int i = prods.size() - 1; i >= 0; i--) begin
                    prods[i].age = prods[i].age + 1;
                    if (prods[i].age > 2) prods.delete(i);
                end
                if (hz.id_valid && hz.id_wr && hz.id_waddr != 4'd0 && !st && !hz.flush) begin
                    p.addr    = hz.id_waddr;
                    p.is_load = hz.id_is_load;
                    p.age     = 0;
                    prods.push_back(p);
                end
            end
        end
    end

    task automatic drive(input bit v, input logic [3:0] rs, input bit rsu, input logic [3:0] rt,
                         input bit rtu, input bit wr, input logic [3:0] wa, input bit ld,
                         input bit fl);
        @(posedge clk);
        #2;
        hz.id_valid   = v;
        hz.id_rs_addr = rs;
        hz.id_rs_used = rsu & v;
        hz.id_rt_addr = rt;
        hz.id_rt_used = rtu & v;
        hz.id_wr      = wr & v;
        hz.id_waddr   = wa;
        hz.id_is_load = ld & v;
        hz.flush      = fl;
        #4;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bit held;
        hz.id_valid = 0; hz.id_rs_addr = 0; hz.id_rs_used = 0; hz.id_rt_addr = 0;
        hz.id_rt_used = 0; hz.id_wr = 0; hz.id_waddr = 0; hz.id_is_load = 0; hz.flush = 0;
        #1 rst = 1'b0;
        #2;
        check("rst_stall", {15'd0, hz.stall}, 16'd0);
        check("rst_cnt", hz.stall_cnt, 16'd0);
        @(posedge clk);
        #2 rst = 1'b1;
        #4;
        check("rst_fwd_rs", {14'd0, hz.fwd_rs_sel}, 16'd0);
        check("rst_fwd_rt", {14'd0, hz.fwd_rt_sel}, 16'd0);

        // add r1 ; add r2,r1,r3
        drive(1, 2, 1, 3, 1, 1, 1, 0, 0);
        check("a_prod_stall", {15'd0, hz.stall}, 16'd0);
        drive(1, 1, 1, 3, 1, 1, 2, 0, 0);
`ifdef HAZARD_FORWARD_EN
        check("a_fwd_nostall", {15'd0, hz.stall}, 16'd0);
        nops(1);
        check("a_fwd_rs_ma", {14'd0, hz.fwd_rs_sel}, 16'd1);
        check("a_fwd_rt_reg", {14'd0, hz.fwd_rt_sel}, 16'd0);
        check("a_cnt", hz.stall_cnt, 16'd0);
`else
        check("a_stall1", {15'd0, hz.stall}, 16'd1);
        drive(1, 1, 1, 3, 1, 1, 2, 0, 0);
        check("a_stall2", {15'd0, hz.stall}, 16'd1);
        drive(1, 1, 1, 3, 1, 1, 2, 0, 0);
        check("a_proceed", {15'd0, hz.stall}, 16'd0);
        check("a_cnt", hz.stall_cnt, 16'd2);
`endif
        nops(3);

        // lw r4 ; add r5,r4,r4
        drive(1, 0, 0, 0, 0, 1, 4, 1, 0);
        drive(1, 4, 1, 4, 1, 1, 5, 0, 0);
        check("b_stall1", {15'd0, hz.stall}, 16'd1);
        drive(1, 4, 1, 4, 1, 1, 5, 0, 0);
`ifdef HAZARD_FORWARD_EN
        check("b_release", {15'd0, hz.stall}, 16'd0);
        nops(1);
        check("b_fwd_rs_wb", {14'd0, hz.fwd_rs_sel}, 16'd2);
        check("b_fwd_rt_wb", {14'd0, hz.fwd_rt_sel}, 16'd2);
        check("b_cnt", hz.stall_cnt, 16'd1);
`else
        check("b_stall2", {15'd0, hz.stall}, 16'd1);
        drive(1, 4, 1, 4, 1, 1, 5, 0, 0);
        check("b_release", {15'd0, hz.stall}, 16'd0);
        nops(1);
        check("b_fwd_rs_reg", {14'd0, hz.fwd_rs_sel}, 16'd0);
        check("b_cnt", hz.stall_cnt, 16'd4);
`endif
        nops(3);

        // write r0 then read r0
        drive(1, 0, 0, 0, 0, 1, 0, 0, 0);
        drive(1, 0, 1, 0, 1, 1, 6, 0, 0);
        check("c_r0_stall", {15'd0, hz.stall}, 16'd0);
        nops(1);
        check("c_r0_rs", {14'd0, hz.fwd_rs_sel}, 16'd0);
        check("c_r0_rt", {14'd0, hz.fwd_rt_sel}, 16'd0);
        nops(3);

        // dependent decode squashed by flush
        drive(1, 0, 0, 0, 0, 1, 6, 0, 0);
        drive(1, 6, 1, 0, 0, 1, 7, 0, 1);
        check("d_flush_stall", {15'd0, hz.stall}, 16'd0);
        drive(1, 7, 1, 0, 0, 1, 8, 0, 0);
        check("d_after_stall", {15'd0, hz.stall}, 16'd0);
        check("d_flush_sel", {14'd0, hz.fwd_rs_sel}, 16'd0);
        nops(3);

        // jal writes $ra, consumer reads it
        drive(1, 0, 0, 0, 0, 1, REG_RA, 0, 0);
        drive(1, REG_RA, 1, 0, 0, 1, 9, 0, 0);
`ifdef HAZARD_FORWARD_EN
        check("e_ra_stall", {15'd0, hz.stall}, 16'd0);
        nops(1);
        check("e_ra_fwd", {14'd0, hz.fwd_rs_sel}, 16'd1);
`else
        check("e_ra_stall", {15'd0, hz.stall}, 16'd1);
`endif
        nops(3);

        // randomized traffic; a stalled instruction is held in decode
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            held = hz.stall && !hz.flush;
            @(posedge clk);
            #2;
            if (!held) begin
                hz.id_valid   = ($urandom_range(0, 3) != 0);
                hz.id_rs_addr = ($urandom_range(0, 9) == 0) ? REG_RA : 4'($urandom_range(0, 3));
                hz.id_rt_addr = 4'($urandom_range(0, 3));
                hz.id_rs_used = hz.id_valid && ($urandom_range(0, 3) != 0);
                hz.id_rt_used = hz.id_valid && ($urandom_range(0, 1) != 0);
                hz.id_wr      = hz.id_valid && ($urandom_range(0, 3) != 0);
                hz.id_waddr   = ($urandom_range(0, 9) == 0) ? REG_RA : 4'($urandom_range(0, 3));
                hz.id_is_load = hz.id_valid && ($urandom_range(0, 2) == 0);
            end
            hz.flush = ($urandom_range(0, 7) == 0);
        end
        nops(3);

        // hold stall for 70000 cycles to saturate the counter
        @(posedge clk);
        #2;
        force dut.stall_c = 1'b1;
        forced = 1'b1;
        repeat (70000) @(posedge clk);
        #2;
        release dut.stall_c;
        forced = 1'b0;
        #4;
        check("cnt_saturated", hz.stall_cnt, 16'hFFFF);

        // reset in the middle of a real load-use stall
        drive(1, 0, 0, 0, 0, 1, 1, 1, 0);
        drive(1, 1, 1, 0, 0, 1, 2, 0, 0);
        check("f_stall", {15'd0, hz.stall}, 16'd1);
        check("f_cnt_hold", hz.stall_cnt, 16'hFFFF);
        #1 rst = 1'b0;
        #1;
        check("f_rst_stall", {15'd0, hz.stall}, 16'd0);
        check("f_rst_cnt", hz.stall_cnt, 16'd0);
        check("f_rst_rs", {14'd0, hz.fwd_rs_sel}, 16'd0);
        check("f_rst_rt", {14'd0, hz.fwd_rt_sel}, 16'd0);
        @(posedge clk);
        #2 rst = 1'b1;
        #4;
        check("f_post_rst_stall", {15'd0, hz.stall}, 16'd0);
        nops(1);
        check("f_post_rst_rs", {14'd0, hz.fwd_rs_sel}, 16'd0);
        nops(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
